// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes,
// default AXI4-Lite channel structs and the address-to-index decoder.
package axi_lite_reg_bank_pkg;

    // Response encodings, bit-identical to axi_pkg::RESP_OKAY / RESP_SLVERR.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Default AXI4-Lite channel layout (32-bit address, 32-bit data).
    typedef struct packed {
        logic [31:0] addr;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_lite_r_t r;
        logic        r_valid;
    } axi_lite_resp_t;

    // Result of decoding a bus address into a register index.
    typedef struct packed {
        logic [31:0] idx;
        logic        oor;
    } reg_idx_t;

    // Drops the byte-offset bits and flags indices beyond the register count.
    function automatic reg_idx_t reg_idx(input logic [63:0] addr,
                                         input int unsigned data_width,
                                         input int unsigned num_regs);
        reg_idx_t    res_s;
        logic [63:0] off_s;
        off_s     = (data_width == 32'd64) ? (addr >> 3'd3) : (addr >> 3'd2);
        res_s.idx = off_s[31:0];
        res_s.oor = (off_s >= 64'(num_regs));
        return res_s;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank_cell.sv
// One register of the bank: byte-lane merge of bus write and hardware load,
// read-only gating, storage flop and the write-success pulse.
module axi_lite_reg_bank_cell
    import axi_lite_reg_bank_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] RstVal    = '0,
    parameter logic                 ReadOnly  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   bus_we,
    input  logic [DataWidth-1:0]   bus_data,
    input  logic [DataWidth/8-1:0] bus_strb,
    input  logic                   hw_load,
    input  logic [DataWidth-1:0]   hw_data,
    output logic [DataWidth-1:0]   q,
    output logic                   wr_pulse
);

    logic                 bus_wr_s;
    logic [DataWidth-1:0] d_s;
    logic [DataWidth-1:0] q_r;
    logic                 pulse_r;

    // Per byte: strobed bus data wins, else hardware load data, else hold.
    always_comb begin
        bus_wr_s = bus_we && !ReadOnly;
        d_s      = q_r;
        for (int unsigned b = 32'd0; b < DataWidth / 32'd8; b++) begin
            if (bus_wr_s && bus_strb[b]) begin
                d_s[32'd8*b +: 8] = bus_data[32'd8*b +: 8];
            end else if (hw_load) begin
                d_s[32'd8*b +: 8] = hw_data[32'd8*b +: 8];
            end else begin
                d_s[32'd8*b +: 8] = q_r[32'd8*b +: 8];
            end
        end
    end

    // Storage and one-cycle pulse for every accepted writable bus write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_r     <= RstVal;
            pulse_r <= 1'b0;
        end else begin
            q_r     <= d_s;
            pulse_r <= bus_wr_s;
        end
    end

    assign q        = q_r;
    assign wr_pulse = pulse_r;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank slave: address decode, single-entry B and R
// response registers and the read mux; storage lives in the cells.
module axi_lite_reg_bank
    import axi_lite_reg_bank_pkg::*;
#(
    parameter int unsigned                          NumRegs   = 8,
    parameter int unsigned                          AddrWidth = 32,
    parameter int unsigned                          DataWidth = 32,
    parameter logic [NumRegs-1:0][DataWidth-1:0]    RegRstVal = '0,
    parameter logic [NumRegs-1:0]                   ReadOnly  = '0,
    parameter type                                  req_t     = axi_lite_req_t,
    parameter type                                  resp_t    = axi_lite_resp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  req_t                               slv_req_i,
    output resp_t                              slv_resp_o,
    input  logic [NumRegs-1:0]                 reg_load_i,
    input  logic [NumRegs-1:0][DataWidth-1:0]  reg_d_i,
    output logic [NumRegs-1:0][DataWidth-1:0]  reg_q_o,
    output logic [NumRegs-1:0]                 wr_pulse_o
);

    reg_idx_t             w_dec_s;
    reg_idx_t             r_dec_s;
    logic                 aw_hs_s;
    logic                 ar_ready_s;
    logic                 ar_hs_s;
    logic                 wr_err_s;
    logic [NumRegs-1:0]   bus_we_s;
    logic [DataWidth-1:0] rd_mux_s;

    logic                 b_valid_r;
    logic [1:0]           b_resp_r;
    logic                 r_valid_r;
    logic [DataWidth-1:0] r_data_r;
    logic [1:0]           r_resp_r;

    // Decode both addresses, form handshakes, per-register write enables and read mux.
    always_comb begin
        w_dec_s    = reg_idx(64'(slv_req_i.aw.addr), DataWidth, NumRegs);
        r_dec_s    = reg_idx(64'(slv_req_i.ar.addr), DataWidth, NumRegs);
        aw_hs_s    = slv_req_i.aw_valid && slv_req_i.w_valid &&
                     (!b_valid_r || slv_req_i.b_ready);
        ar_ready_s = !r_valid_r || slv_req_i.r_ready;
        ar_hs_s    = slv_req_i.ar_valid && ar_ready_s;
        wr_err_s   = w_dec_s.oor;
        bus_we_s   = '0;
        rd_mux_s   = '0;
        for (int unsigned k = 32'd0; k < NumRegs; k++) begin
            bus_we_s[k] = aw_hs_s && !w_dec_s.oor && (w_dec_s.idx == k);
            wr_err_s    = wr_err_s | (!w_dec_s.oor && (w_dec_s.idx == k) && ReadOnly[k]);
            rd_mux_s    = rd_mux_s | ({DataWidth{r_dec_s.idx == k}} & reg_q_o[k]);
        end
    end

    // B response slot: load on write acceptance, clear once consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_valid_r <= 1'b0;
            b_resp_r  <= 2'b00;
        end else if (aw_hs_s) begin
            b_valid_r <= 1'b1;
            b_resp_r  <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
        end else if (slv_req_i.b_ready) begin
            b_valid_r <= 1'b0;
        end
    end

    // R response slot: capture pre-write data on read acceptance, clear once consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_r <= 1'b0;
            r_data_r  <= '0;
            r_resp_r  <= 2'b00;
        end else if (ar_hs_s) begin
            r_valid_r <= 1'b1;
            r_data_r  <= r_dec_s.oor ? '0 : rd_mux_s;
            r_resp_r  <= r_dec_s.oor ? RESP_SLVERR : RESP_OKAY;
        end else if (slv_req_i.r_ready) begin
            r_valid_r <= 1'b0;
        end
    end

    // Assemble the response struct from the registered slots and combinational readies.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_hs_s;
        slv_resp_o.w_ready  = aw_hs_s;
        slv_resp_o.b.resp   = b_resp_r;
        slv_resp_o.b_valid  = b_valid_r;
        slv_resp_o.ar_ready = ar_ready_s;
        slv_resp_o.r.data   = r_data_r;
        slv_resp_o.r.resp   = r_resp_r;
        slv_resp_o.r_valid  = r_valid_r;
    end

    for (genvar k = 0; k < NumRegs; k++) begin : g_cell
        axi_lite_reg_bank_cell #(
            .DataWidth (DataWidth),
            .RstVal    (RegRstVal[k]),
            .ReadOnly  (ReadOnly[k])
        ) u_cell (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .bus_we   (bus_we_s[k]),
            .bus_data (slv_req_i.w.data),
            .bus_strb (slv_req_i.w.strb),
            .hw_load  (reg_load_i[k]),
            .hw_data  (reg_d_i[k]),
            .q        (reg_q_o[k]),
            .wr_pulse (wr_pulse_o[k])
        );
    end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank: directed transactions push their
// hand-computed responses; a negedge monitor pops and compares on each handshake.
module tb_axi_lite_reg_bank;
    import axi_lite_reg_bank_pkg::*;

    localparam logic [7:0][31:0] RstVals = {32'h0, 32'h0, 32'h0, 32'h0,
                                            32'h0, 32'hCAFE_0001, 32'h0, 32'h0};
    localparam logic [7:0]       RoMask  = 8'b0000_1000;

    logic             clk;
    logic             rst;
    axi_lite_req_t    req;
    axi_lite_resp_t   resp;
    logic [7:0]       load;
    logic [7:0][31:0] d;
    logic [7:0][31:0] q;
    logic [7:0]       pulse;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  exp_b[$];
    logic [31:0] exp_r_data[$];
    logic [1:0]  exp_r_resp[$];
    logic [31:0] b2b_rd[4];

    axi_lite_reg_bank #(
        .NumRegs   (8),
        .AddrWidth (32),
        .DataWidth (32),
        .RegRstVal (RstVals),
        .ReadOnly  (RoMask),
        .req_t     (axi_lite_req_t),
        .resp_t    (axi_lite_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (req),
        .slv_resp_o (resp),
        .reg_load_i (load),
        .reg_d_i    (d),
        .reg_q_o    (q),
        .wr_pulse_o (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed B/R beat against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp.b_valid && req.b_ready) begin
            n_vec++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected: got resp %b expected no response", resp.b.resp);
            end else begin
                logic [1:0] e;
                e = exp_b.pop_front();
                if (resp.b.resp !== e) begin
                    n_err++;
                    $display("FAIL b_resp: got %b expected %b", resp.b.resp, e);
                end
            end
        end
        if (!rst && resp.r_valid && req.r_ready) begin
            n_vec++;
            if (exp_r_data.size() == 0) begin
                n_err++;
                $display("FAIL r_unexpected: got data %h expected no response", resp.r.data);
            end else begin
                logic [31:0] ed;
                logic [1:0]  er;
                ed = exp_r_data.pop_front();
                er = exp_r_resp.pop_front();
                if (resp.r.data !== ed || resp.r.resp !== er) begin
                    n_err++;
                    $display("FAIL r_beat: got %h/%b expected %h/%b", resp.r.data, resp.r.resp, ed, er);
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        bit acc = 1'b0;
        req.aw.addr  = addr;
        req.w.data   = data;
        req.w.strb   = strb;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (resp.aw_ready && resp.w_ready) acc = 1'b1;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL write_timeout: got no aw_ready expected acceptance at %h", addr);
        end else begin
            exp_b.push_back(exp_resp);
            @(posedge clk);
            #1;
            check("b_latency", 32'(resp.b_valid), 32'd1);
        end
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        bit acc = 1'b0;
        req.ar.addr  = addr;
        req.ar_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (resp.ar_ready) acc = 1'b1;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL read_timeout: got no ar_ready expected acceptance at %h", addr);
        end else begin
            exp_r_data.push_back(exp_data);
            exp_r_resp.push_back(exp_resp);
            @(posedge clk);
            #1;
            check("r_latency", 32'(resp.r_valid), 32'd1);
        end
        req.ar_valid = 1'b0;
    endtask

    initial begin
        b2b_rd[0] = 32'h0000_0000;
        b2b_rd[1] = 32'h4000_0000;
        b2b_rd[2] = 32'h4000_0001;
        b2b_rd[3] = 32'h4000_0002;
        rst  = 1'b1;
        req  = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        load = '0;
        d    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_b_valid", 32'(resp.b_valid), 32'd0);
        check("rst_r_valid", 32'(resp.r_valid), 32'd0);
        check("rst_pulse", 32'(pulse), 32'd0);
        check("rst_q2", q[2], 32'hCAFE_0001);
        check("rst_q0", q[0], 32'h0);
        check("rst_ar_ready", 32'(resp.ar_ready), 32'd1);
        check("rst_aw_ready_idle", 32'(resp.aw_ready), 32'd0);
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        #1;
        check("rst_aw_ready_req", 32'(resp.aw_ready), 32'd1);
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset value read and strobed write
        do_read(32'h08, 32'hCAFE_0001, RESP_OKAY);
        do_write(32'h04, 32'h1122_3344, 4'b0101, RESP_OKAY);
        check("wr_pulse1", 32'(pulse), 32'h02);
        check("q1_strb", q[1], 32'h0022_0044);
        @(posedge clk);
        #1;
        check("wr_pulse1_end", 32'(pulse), 32'h00);

        // Errors: read-only and out-of-range
        do_write(32'h0C, 32'hFFFF_FFFF, 4'b1111, RESP_SLVERR);
        check("ro_no_pulse", 32'(pulse), 32'h00);
        check("ro_q3", q[3], 32'h0);
        do_write(32'h40, 32'hFFFF_FFFF, 4'b1111, RESP_SLVERR);
        check("oor_no_pulse", 32'(pulse), 32'h00);
        check("oor_q1", q[1], 32'h0022_0044);
        do_read(32'h40, 32'h0, RESP_SLVERR);
        do_read(32'h0C, 32'h0, RESP_OKAY);

        // Zero-strobe write still pulses
        do_write(32'h14, 32'hDEAD_BEEF, 4'b0000, RESP_OKAY);
        check("strb0_pulse", 32'(pulse), 32'h20);
        check("strb0_q5", q[5], 32'h0);

        // Bus write and hardware load on the same register
        load[0] = 1'b1;
        d[0]    = 32'h1234_5678;
        do_write(32'h00, 32'hAAAA_BBBB, 4'b0011, RESP_OKAY);
        load[0] = 1'b0;
        check("merge_q0", q[0], 32'h1234_BBBB);

        // Hardware load of a read-only register
        load[3] = 1'b1;
        d[3]    = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        load[3] = 1'b0;
        check("hwload_q3", q[3], 32'h5A5A_5A5A);
        do_read(32'h0C, 32'h5A5A_5A5A, RESP_OKAY);

        // B back-pressure with a second write queued
        req.b_ready = 1'b0;
        do_write(32'h18, 32'h600D_F00D, 4'b1111, RESP_OKAY);
        req.aw.addr  = 32'h0C;
        req.w.data   = 32'hFFFF_FFFF;
        req.w.strb   = 4'b1111;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_b_valid", 32'(resp.b_valid), 32'd1);
            check("stall_b_resp", 32'(resp.b.resp), 32'(RESP_OKAY));
            check("stall_aw_ready", 32'(resp.aw_ready), 32'd0);
            check("stall_w_ready", 32'(resp.w_ready), 32'd0);
        end
        @(posedge clk);
        #1 req.b_ready = 1'b1;
        @(negedge clk);
        check("release_aw_ready", 32'(resp.aw_ready), 32'd1);
        exp_b.push_back(RESP_SLVERR);
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        check("release_b_valid", 32'(resp.b_valid), 32'd1);
        check("stall_q6", q[6], 32'h600D_F00D);
        check("stall_q3", q[3], 32'h5A5A_5A5A);

        // Back-to-back reads racing writes to register 4
        for (int i = 0; i < 4; i++) begin
            req.ar.addr  = 32'h10;
            req.ar_valid = 1'b1;
            req.aw.addr  = 32'h10;
            req.w.data   = 32'h4000_0000 + 32'(i);
            req.w.strb   = 4'b1111;
            req.aw_valid = 1'b1;
            req.w_valid  = 1'b1;
            @(negedge clk);
            check("b2b_ar_ready", 32'(resp.ar_ready), 32'd1);
            check("b2b_aw_ready", 32'(resp.aw_ready), 32'd1);
            exp_r_data.push_back(b2b_rd[i]);
            exp_r_resp.push_back(RESP_OKAY);
            exp_b.push_back(RESP_OKAY);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset with responses pending
        req.b_ready  = 1'b0;
        req.r_ready  = 1'b0;
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        check("pre_rst_q4", q[4], 32'h4000_0003);
        #2 rst = 1'b1;
        exp_b.delete();
        exp_r_data.delete();
        exp_r_resp.delete();
        #1;
        check("arst_r_valid", 32'(resp.r_valid), 32'd0);
        check("arst_b_valid", 32'(resp.b_valid), 32'd0);
        check("arst_q4", q[4], 32'h0);
        check("arst_q2", q[2], 32'hCAFE_0001);
        check("arst_q1", q[1], 32'h0);
        check("arst_q3", q[3], 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        do_write(32'h1C, 32'h0BAD_CAFE, 4'b1100, RESP_OKAY);
        do_read(32'h1C, 32'h0BAD_0000, RESP_OKAY);

        repeat (3) @(posedge clk);
        #1;
        check("b_drained", 32'(exp_b.size()), 32'd0);
        check("r_drained", 32'(exp_r_data.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

AXI4-Lite register-bank slave that terminates one master port of the AXI4-Lite crossbar. It holds `NumRegs` data-width registers, written with byte strobes and read over the bus. Hardware can also load the registers and observe them directly. It answers every request with OKAY or SLVERR, so the crossbar's decode-error path never sees traffic that targets this block.

## Interface
Parameters:
- `NumRegs`, 8, number of registers; must be ≥ 1.
- `AddrWidth`, 32, width of the AW/AR `addr` field.
- `DataWidth`, 32, register and bus data width; must be 32 or 64.
- `RegRstVal`, '0, packed `[NumRegs-1:0][DataWidth-1:0]` reset values.
- `ReadOnly`, '0, `[NumRegs-1:0]` mask; a set bit makes that register read-only from the bus.
- `req_t`, logic, AXI4-Lite request struct type.
- `resp_t`, logic, AXI4-Lite response struct type.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `slv_req_i`  in  req_t  AXI4-Lite request.
- `slv_resp_o`  out  resp_t  AXI4-Lite response.
- `reg_load_i`  in  NumRegs  per-register hardware load enable.
- `reg_d_i`  in  NumRegs×DataWidth  hardware load data.
- `reg_q_o`  out  NumRegs×DataWidth  current register contents.
- `wr_pulse_o`  out  NumRegs  one-cycle pulse when a bus write to that register succeeds.

## Operation
- Register index:
  - Offset = `addr[AddrWidth-1:0]`, with the low $clog2(DataWidth/8) bits ignored.
  - Index = offset >> $clog2(DataWidth/8).
  - If index ≥ NumRegs, the access is out of range.
- Write path:
  - A write is accepted only when `aw_valid` and `w_valid` are both high and the B slot is free (`!b_valid || b_ready`).
  - `aw_ready` and `w_ready` assert together in that cycle, combinationally.
  - An in-range write to a writable register updates each byte whose `w.strb` bit is set, at the accepting edge.
  - `wr_pulse_o[idx]` is high in the following cycle, even when `strb` = 0.
  - A write to an out-of-range or `ReadOnly` register changes nothing, raises no pulse, and returns `b.resp` = SLVERR (2'b10). Otherwise `b.resp` = OKAY.
- Read path:
  - `ar_ready` = `!r_valid || r_ready`.
  - On acceptance, read data is captured into the R register.
  - An out-of-range read returns `r.data` = 0 and `r.resp` = SLVERR.
- Hardware load: when `reg_load_i[k]` is high, `reg_d_i[k]` is written to register k at the edge. This applies to `ReadOnly` registers as well.
- Priority when a bus write and a hardware load hit the same register in the same cycle:
  - Strobed bytes take the bus data.
  - Unstrobed bytes take `reg_d_i`.
- A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Response channels:
  - B and R are each a single-entry output register.
  - `b_valid` and `r_valid` stay high, with stable payload, until their ready signal is sampled high.
  - A new response may be loaded in the same cycle the old one is consumed.
- The write and read paths are fully independent; neither one stalls the other.

## Timing
- Reset values:
  - `b_valid`, `r_valid`: 0.
  - B/R payload: 0.
  - `reg_q_o`: `RegRstVal`.
  - `wr_pulse_o`: 0.
- `aw_ready`, `w_ready` and `ar_ready` are combinational. During reset they evaluate to the reset-state values, i.e. ready whenever the response slot is empty.
- Latency:
  - Write acceptance to `b_valid`: 1 cycle.
  - Read acceptance to `r_valid`: 1 cycle.
- Throughput: one write and one read per cycle while `b_ready` and `r_ready` are held high.
- `reg_q_o` reflects a write or load from the cycle after the edge at which it is applied.
- Reset asserted mid-transaction:
  - All pending responses are dropped.
  - Registers return to `RegRstVal` immediately (asynchronous).
- AW without W, or W without AW: nothing is accepted, and both ready signals stay low.

## Structure
- Shared package `axi_lite_reg_bank_pkg` holds:
  - The resp constants (reuse `axi_pkg::RESP_OKAY` and `axi_pkg::RESP_SLVERR`).
  - An index-decode function `reg_idx(addr, DataWidth, NumRegs)` that returns the index and an out-of-range flag.
- One sub-module, `axi_lite_reg_bank_cell`, one instance per register. It holds:
  - The byte-lane merge of bus strobe, hardware load and read-only logic.
  - The storage flop with asynchronous active-high reset.
- The top level contains only:
  - Decode logic.
  - The B and R output registers.
  - The read mux.

## Test plan
- After reset, with `RegRstVal[2]` = 32'hCAFE_0001: read addr 0x08 → R one cycle after `ar` acceptance, data 32'hCAFE_0001, OKAY.
- Write addr 0x04, data 32'h1122_3344, strb 4'b0101 onto reset value 0 → B OKAY one cycle later; `wr_pulse_o[1]` for one cycle; `reg_q_o[1]` = 32'h0022_0044.
- Write to `ReadOnly` register 3, then write to addr 0x40 with NumRegs = 8 → both return SLVERR; registers unchanged; no pulse. Read addr 0x40 → data 0, SLVERR.
- Same cycle: bus write to reg 0 (strb 4'b0011, data 32'hAAAA_BBBB) and `reg_load_i[0]` with 32'h1234_5678 → `reg_q_o[0]` = 32'h1234_BBBB.
- `b_ready` held low for 5 cycles after a write → `b_valid` stays high with stable resp; `aw_ready` and `w_ready` stay low for a second queued write until `b_ready` rises; then the second write is accepted in that same cycle.
- Back-to-back reads with `r_ready` = 1, concurrent with writes to the same register → one R per cycle; each read shows the pre-write value of its acceptance cycle. Assert `rst_i` mid-stream → `r_valid` and `b_valid` drop, and `reg_q_o` = `RegRstVal`, without waiting for a clock edge.
